clk_gen_multi: RTL

Multi-channel programmable clock-divider block for the MIPS processor, generating N_CH divided processor-clock waveforms from the board clock. Each channel has its own run-time-programmable half-period, halt-at-high parking, and optional single-step release. Channel 0 drives the CPU clock; other channels drive peripherals and debug logic.

---
 rtl/clk_gen_pkg.sv | 20 ++
 rtl/clk_gen_ch.sv | 95 +++++++++
 rtl/clk_gen_multi.sv | 54 +++++
 3 files changed

// File: rtl/clk_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen_pkg
// Brief    : Shared defaults and types for the clk_gen_multi clock divider.
// Revision : 1.0 - initial release
// ============================================================================
package clk_gen_pkg;

    localparam int C_DIV_W       = 16;
    localparam int C_DEFAULT_DIV = 2500;

    typedef logic [C_DIV_W-1:0] div_t;

    // Channel-select width: clog2 of the channel count, never below one bit.
    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_gen_ch.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen_ch
// Brief    : One divided-clock channel: counter, shadowed divisor, halt-high
//            parking and (with CLK_GEN_STEP_EN defined) single-step release.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gen_ch
    import clk_gen_pkg::*;
#(
    parameter int DIV_W       = C_DIV_W,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_data,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             clk_out,
    output logic             rise,
    output logic             halted
);

    localparam logic [DIV_W-1:0] C_RST_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_div_shadow;
    logic             r_clk_out;
    logic             r_rise;
    logic             w_step_pend;
    logic             w_park;
    logic             w_run;
    logic             w_wrap;

    // Park point is the first cycle of a high phase.
    assign w_park = halt_req && r_clk_out && (r_cnt == '0);
    assign w_run  = !w_park || w_step_pend;
    assign w_wrap = (r_cnt == r_div_act);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_div_act    <= C_RST_DIV;
            r_div_shadow <= C_RST_DIV;
            r_clk_out    <= 1'b0;
            r_rise       <= 1'b0;
        end else begin
            if (div_wr) begin
                r_div_shadow <= div_data;
            end
            r_rise <= 1'b0;
            if (w_run) begin
                if (w_wrap) begin
                    // Old shadow is loaded even when a write lands this cycle.
                    r_cnt     <= '0;
                    r_clk_out <= !r_clk_out;
                    r_div_act <= r_div_shadow;
                    r_rise    <= !r_clk_out;
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end
            end
        end
    end

`ifdef CLK_GEN_STEP_EN
    logic r_step_pend;

    // A pending step forces one advancing cycle, which also clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_pend <= 1'b0;
        end else if (r_step_pend) begin
            r_step_pend <= 1'b0;
        end else if (step_req && w_park) begin
            r_step_pend <= 1'b1;
        end
    end

    assign w_step_pend = r_step_pend;
`else
    logic w_unused_step;

    assign w_step_pend   = 1'b0;
    assign w_unused_step = step_req;
`endif

    assign clk_out = r_clk_out;
    assign rise    = r_rise;
    assign halted  = w_park && !w_step_pend;

endmodule
`default_nettype wire

// File: rtl/clk_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen_multi
// Brief    : N_CH independent programmable clock dividers with halt and
//            single-step control; single-step present when CLK_GEN_STEP_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DIV_W       = C_DIV_W,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV,
    parameter int SEL_W       = sel_width(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [DIV_W-1:0] div_data,
    input  logic [N_CH-1:0]  halt_req,
    input  logic [N_CH-1:0]  step_req,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  rise,
    output logic [N_CH-1:0]  halted
);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic w_wr;

            // Full-width compare: selects at or above N_CH match no channel.
            assign w_wr = div_wr && (div_sel == SEL_W'(i));

            clk_gen_ch #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .div_wr   (w_wr),
                .div_data (div_data),
                .halt_req (halt_req[i]),
                .step_req (step_req[i]),
                .clk_out  (clk_out[i]),
                .rise     (rise[i]),
                .halted   (halted[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
